// File: rtl/sram_fifo_pkg.sv
// Shared sizing constants for the SRAM-backed FIFO controller and its output buffer.
package sram_fifo_pkg;

  localparam int DATA_WIDTH_DEF = 150;
  localparam int ADDR_WIDTH_DEF = 9;
  localparam int DEPTH_DEF      = 2 ** ADDR_WIDTH_DEF;
  localparam int OUTBUF_DEPTH   = 2;
  localparam int OB_LVL_W       = 2;

  typedef logic [OB_LVL_W-1:0] ob_level_t;

endpackage

// File: rtl/sram_fifo_outbuf.sv
// Two-entry valid/ready FIFO that holds words returned by the SRAM until the consumer takes them.
module sram_fifo_outbuf
  import sram_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_valid,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output ob_level_t             level
);

  logic [DATA_WIDTH-1:0] mem_r [OUTBUF_DEPTH];
  logic                  head_r;
  logic                  tail_r;
  ob_level_t             level_r;
  logic                  pop_s;

  assign pop_s     = (level_r != 2'd0) && pop_ready;
  assign out_valid = (level_r != 2'd0);
  assign out_data  = mem_r[head_r];
  assign level     = level_r;

  // Storage, pointers and fill level; the controller never pushes into a full buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < OUTBUF_DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      head_r  <= 1'b0;
      tail_r  <= 1'b0;
      level_r <= 2'd0;
    end else begin
      if (push_valid) begin
        mem_r[tail_r] <= push_data;
        tail_r        <= ~tail_r;
      end
      if (pop_s) begin
        head_r <= ~head_r;
      end
      case ({push_valid, pop_s})
        2'b10:   level_r <= level_r + 2'd1;
        2'b01:   level_r <= level_r - 2'd1;
        default: level_r <= level_r;
      endcase
    end
  end

endmodule

// File: rtl/sram_fifo_ctrl.sv
// FIFO controller driving one external single-port SRAM, with a small output buffer
// that hides the one-cycle SRAM read latency from the consumer.
module sram_fifo_ctrl
  import sram_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  sram_csb,
  output logic                  sram_web,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_din,
  input  logic [DATA_WIDTH-1:0] sram_dout,
  output logic [ADDR_WIDTH:0]   count
);

  localparam logic [ADDR_WIDTH:0]   DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   CNT_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [ADDR_WIDTH-1:0] wr_ptr_r;
  logic [ADDR_WIDTH-1:0] rd_ptr_r;
  logic [ADDR_WIDTH:0]   count_r;
  logic                  rd_pending_r;
  ob_level_t             ob_level_s;
  logic [2:0]            occupancy_s;
  logic                  rd_issue_s;
  logic                  in_ready_s;
  logic                  wr_en_s;

  // A read may only be issued when its returning word is guaranteed a buffer slot,
  // counting the read already in flight; out_ready is deliberately not consulted.
  assign occupancy_s = {1'b0, ob_level_s} + {2'b00, rd_pending_r};
  assign rd_issue_s  = (count_r != {(ADDR_WIDTH+1){1'b0}}) && (occupancy_s < 3'd2);
  assign in_ready_s  = !rst && (count_r < DEPTH_C) && !rd_issue_s;
  assign wr_en_s     = in_valid && in_ready_s;
  assign in_ready    = in_ready_s;
  assign count       = count_r;

  // SRAM port request: read wins, otherwise a write for an accepted word, otherwise idle.
  always_comb begin
    sram_csb  = 1'b1;
    sram_web  = 1'b1;
    sram_addr = {ADDR_WIDTH{1'b0}};
    sram_din  = {DATA_WIDTH{1'b0}};
    if (rd_issue_s) begin
      sram_csb  = 1'b0;
      sram_addr = rd_ptr_r;
    end else if (wr_en_s) begin
      sram_csb  = 1'b0;
      sram_web  = 1'b0;
      sram_addr = wr_ptr_r;
      sram_din  = in_data;
    end else begin
      sram_csb  = 1'b1;
      sram_web  = 1'b1;
    end
  end

  // Pointers wrap naturally at DEPTH; count tracks words resident in the SRAM only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r     <= {ADDR_WIDTH{1'b0}};
      rd_ptr_r     <= {ADDR_WIDTH{1'b0}};
      count_r      <= {(ADDR_WIDTH+1){1'b0}};
      rd_pending_r <= 1'b0;
    end else begin
      rd_pending_r <= rd_issue_s;
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
        count_r  <= count_r + CNT_ONE;
      end else if (rd_issue_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
        count_r  <= count_r - CNT_ONE;
      end
    end
  end

  sram_fifo_outbuf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_outbuf (
    .clk       (clk),
    .rst       (rst),
    .push_valid(rd_pending_r),
    .push_data (sram_dout),
    .pop_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .level     (ob_level_s)
  );

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Randomised bench for sram_fifo_ctrl with a behavioural SRAM and a queue-based FIFO model.
module tb_sram_fifo_ctrl;

  localparam int DW    = 150;
  localparam int AW    = 9;
  localparam int DEPTH = 512;
  localparam int CAP   = DEPTH + 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          sram_csb;
  logic          sram_web;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_din;
  logic [DW-1:0] sram_dout;
  logic [AW:0]   count;

  logic [DW-1:0] sram_mem [0:DEPTH-1];
  logic [DW-1:0] q[$];
  int n_cmp = 0;
  int n_err = 0;
  int n_acc = 0;
  int n_pop = 0;
  int wr_n  = 0;
  int rd_n  = 0;

  always #5 clk = ~clk;

  sram_fifo_ctrl dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .sram_csb(sram_csb), .sram_web(sram_web), .sram_addr(sram_addr),
    .sram_din(sram_din), .sram_dout(sram_dout), .count(count)
  );

  // Behavioural single-port SRAM: synchronous write, read data appears after the read edge.
  always @(posedge clk) begin
    if (!sram_csb) begin
      if (!sram_web) sram_mem[sram_addr] <= sram_din;
      else           sram_dout <= sram_mem[sram_addr];
    end
  end

  task automatic check_eq(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_word();
    logic [159:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return t[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] idx_word(input int v);
    logic [DW-1:0] t;
    t = '0;
    t[31:0] = v;
    return t;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_csb"},  sram_csb,  1'b1);
    check_eq({tag, "_web"},  sram_web,  1'b1);
    check_eq({tag, "_addr"}, sram_addr, 0);
    check_eq({tag, "_din"},  sram_din,  0);
    check_eq({tag, "_ir"},   in_ready,  1'b0);
    check_eq({tag, "_ov"},   out_valid, 1'b0);
    check_eq({tag, "_od"},   out_data,  0);
    check_eq({tag, "_cnt"},  count,     0);
  endtask

  task automatic model_reset();
    q.delete();
    wr_n = 0;
    rd_n = 0;
  endtask

  // One clock cycle: drive, sample before the edge, check against the model, then commit the model.
  task automatic step(input logic iv, input logic [DW-1:0] d, input logic ordy);
    logic ir_alt, csb_alt, acc, pop;
    @(negedge clk);
    in_valid  = iv;
    in_data   = d;
    out_ready = ~ordy;
    #1;
    ir_alt  = in_ready;
    csb_alt = sram_csb;
    out_ready = ordy;
    #1;
    check_eq("ir_indep", in_ready, ir_alt);
    check_eq("csb_indep", sram_csb, csb_alt);
    acc = iv && in_ready;
    pop = out_valid && ordy;
    if (out_valid) begin
      check_eq("ov_nonempty", q.size() != 0, 1'b1);
      if (q.size() != 0) check_eq("order", out_data, q[0]);
    end
    if (q.size() >= CAP) check_eq("full_ir", in_ready, 1'b0);
    check_eq("cnt_rng", (count <= DEPTH) && (q.size() >= int'(count)) && (q.size() - int'(count) <= 2), 1'b1);
    check_eq("wr_is_acc", !sram_csb && !sram_web, acc);
    if (!sram_csb && !sram_web) begin
      check_eq("wr_addr", sram_addr, wr_n % DEPTH);
      check_eq("wr_din", sram_din, d);
    end
    if (!sram_csb && sram_web) begin
      check_eq("rd_addr", sram_addr, rd_n % DEPTH);
      rd_n++;
    end
    if (pop && q.size() != 0) begin
      void'(q.pop_front());
      n_pop++;
    end
    if (acc) begin
      q.push_back(d);
      n_acc++;
      wr_n++;
    end
  endtask

  initial begin
    logic [DW-1:0] w;
    int a0, p0, cyc;
    rst = 1'b1;
    in_valid = 1'b1;
    in_data = rnd_word();
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check_reset_outputs("rst");
    rst = 1'b0;
    in_valid = 1'b0;

    // Single word latency through an empty FIFO
    w = rnd_word();
    w[7:0] = 8'hA5;
    step(1'b1, w, 1'b1);
    check_eq("lat_accept", in_ready, 1'b1);
    step(1'b0, '0, 1'b1);
    check_eq("lat_e0", out_valid, 1'b0);
    step(1'b0, '0, 1'b1);
    check_eq("lat_e1", out_valid, 1'b0);
    step(1'b0, '0, 1'b1);
    check_eq("lat_e2_ov", out_valid, 1'b1);
    check_eq("lat_e2_data", out_data, w);
    step(1'b0, '0, 1'b1);
    check_eq("lat_done_ov", out_valid, 1'b0);
    check_eq("lat_done_cnt", count, 0);

    // Fill to full capacity with a stalled consumer
    a0 = n_acc;
    repeat (600) step(1'b1, idx_word(n_acc - a0), 1'b0);
    check_eq("fill_acc", n_acc - a0, CAP);
    step(1'b1, idx_word(n_acc - a0), 1'b0);
    check_eq("full_ir_low", in_ready, 1'b0);
    check_eq("full_cnt", count, DEPTH);
    check_eq("full_csb", sram_csb, 1'b1);
    check_eq("full_ov", out_valid, 1'b1);
    check_eq("full_head", out_data, idx_word(0));

    // Drain everything in write order
    p0 = n_pop;
    repeat (1100) step(1'b0, '0, 1'b1);
    check_eq("drain_pops", n_pop - p0, CAP);
    check_eq("drain_ov", out_valid, 1'b0);
    check_eq("drain_cnt", count, 0);

    // Random traffic, 2000 words, pointers wrap several times
    a0 = n_acc;
    cyc = 0;
    while ((n_acc - a0 < 2000) && (cyc < 20000)) begin
      step(1'($urandom_range(0, 1)), rnd_word(), 1'($urandom_range(0, 1)));
      cyc++;
    end
    check_eq("rand_acc", n_acc - a0, 2000);
    cyc = 0;
    while ((q.size() != 0) && (cyc < 3000)) begin
      step(1'b0, '0, 1'b1);
      cyc++;
    end
    check_eq("rand_drained", q.size(), 0);
    check_eq("rand_cnt", count, 0);

    // Reset in the middle of traffic with a read in flight
    a0 = n_acc;
    cyc = 0;
    while ((n_acc - a0 < 103) && (cyc < 400)) begin
      step(1'b1, rnd_word(), 1'b0);
      cyc++;
    end
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);
    check_eq("mid_rd_issue", {sram_csb, sram_web}, 2'b01);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = rnd_word();
    out_ready = 1'b1;
    rst = 1'b1;
    #1;
    check_reset_outputs("mid_rst");
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check_reset_outputs("mid_rst_hold");
    rst = 1'b0;
    in_valid = 1'b0;
    p0 = n_pop;
    step(1'b1, idx_word(1), 1'b1);
    check_eq("post_rst_ir", in_ready, 1'b1);
    repeat (4) step(1'b0, '0, 1'b1);
    check_eq("post_rst_pops", n_pop - p0, 1);

    // Continuous producer and consumer from a partially filled FIFO
    repeat (20) step(1'b1, rnd_word(), 1'b0);
    p0 = n_pop;
    repeat (1000) step(1'b1, rnd_word(), 1'b1);
    check_eq("throughput", (n_pop - p0) >= 500, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sram_fifo_ctrl.md
SRAM_FIFO_CTRL -- requirements
Module: sram_fifo_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 150, word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 9, SRAM address width; DEPTH = 2**ADDR_WIDTH (512).
REQ-003 SHALL have one clock and reset: asynchronous, active-high reset.
REQ-004 clk  in  1  sole clock; shared with SRAM clk0.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 in_valid  in  1  producer word valid.
REQ-007 in_ready  out  1  controller accepts word this cycle.
REQ-008 in_data  in  DATA_WIDTH  producer word.
REQ-009 out_valid  out  1  out_data valid.
REQ-010 out_ready  in  1  consumer accepts word.
REQ-011 out_data  out  DATA_WIDTH  head-of-FIFO word.
REQ-012 sram_csb  out  1  to csb0, active-low select.
REQ-013 sram_web  out  1  to web0, active-low write enable.
REQ-014 sram_addr  out  ADDR_WIDTH  to addr0.
REQ-015 sram_din  out  DATA_WIDTH  to din0.
REQ-016 sram_dout  in  DATA_WIDTH  from dout0; valid one edge after read edge.
REQ-017 count  out  ADDR_WIDTH+1  words resident in SRAM, 0..DEPTH.

Function
REQ-018 SHALL be a FIFO built on one single-port SRAM, at most one SRAM access (read or write) per cycle.
REQ-019 SHALL hold a 2-entry output buffer; total capacity DEPTH+2 (514).
REQ-020 Read issue: count>0 and (buffer entries + read in flight) < 2; read SHALL take priority over write.
REQ-021 in_ready SHALL be 1 iff not in reset, count<DEPTH, and no read issued this cycle; derived from registered state only, never from out_ready.
REQ-022 SRAM controls SHALL be combinational from registered state and in_valid: write -> csb=0, web=0, addr=wr_ptr, din=in_data; read -> csb=0, web=1, addr=rd_ptr; idle -> csb=1, web=1.
REQ-023 Write accept (in_valid&in_ready) SHALL write SRAM at that edge, increment wr_ptr.
REQ-024 Read issue SHALL increment rd_ptr and set rd_pending; next edge SHALL capture sram_dout into output buffer tail.
REQ-025 Pointers SHALL wrap DEPTH-1 -> 0 via natural ADDR_WIDTH overflow.
REQ-026 count SHALL be +1 on write, -1 on read issue, unchanged otherwise (never both same cycle).
REQ-027 out_valid SHALL be 1 iff buffer non-empty; out_data = buffer head; pop on out_valid&out_ready.
REQ-028 Buffer capture and pop in same cycle SHALL both occur; word order preserved.
REQ-029 Latency, empty FIFO: accept at edge E0, read at E1, out_valid high after E2; no bypass path.
REQ-030 out_data SHALL remain stable while out_valid&!out_ready.
REQ-031 Sustained throughput SHALL be >= 1 word / 2 cycles with continuous producer and consumer.

Reset
REQ-032 While rst=1: sram_csb=1, sram_web=1, sram_addr=0, sram_din=0, in_ready=0, out_valid=0, out_data=0, count=0.
REQ-033 rst SHALL clear wr_ptr, rd_ptr, rd_pending, buffer; contents and in-flight read discarded; SRAM contents don't-care.
REQ-034 First accept allowed on first clk edge after rst deasserts.

Structure
REQ-035 Package sram_fifo_pkg SHALL hold DATA_WIDTH, ADDR_WIDTH, DEPTH defaults and buffer depth constant (2).
REQ-036 Output buffer SHALL be sub-module sram_fifo_outbuf (2-entry valid/ready FIFO, push from sram_dout capture).
REQ-037 SRAM instance SHALL live outside this block; controller connects by port only.

Verification
REQ-038 Single word 0x...A5 into empty FIFO, out_ready=1 -> out_valid high 2 cycles after accept, data 0x...A5, count returns 0.
REQ-039 out_ready=0, in_valid=1 for 600 cycles -> exactly 514 accepts, in_ready low thereafter, count=512, sram_csb=1 when idle.
REQ-040 Then out_ready=1 -> 514 words out in write order (incrementing pattern 0..513), out_valid drops, count=0.
REQ-041 2000 words, random in_valid/out_ready at 50% -> order preserved, never csb=0 twice per cycle, wr_ptr/rd_ptr wrap past 511 correctly.
REQ-042 rst pulsed mid-stream (count=100, read in flight) -> all outputs to REQ-032 values immediately; post-reset word 0x1 is first out.
REQ-043 Continuous producer and consumer for 1000 cycles -> >= 500 words delivered, no in_ready/out_ready combinational dependency.
